// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester scratch-RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last_gnt,
    output logic    valid,
    output req_id_t winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = REQ_A;
        if (req_a && req_b) begin
            winner = (last_gnt == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one scratch-RAM port between clients A and B (IDLE -> ACCESS -> RESP).
// Optional grant counters are enabled with `define RAM_ARB_STATS_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [7:0]        gnt_cnt_a,
    output logic [7:0]        gnt_cnt_b
`endif
);

    state_t              state_q, state_d;
    req_id_t             last_gnt_q;
    req_id_t             sel_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                pick_valid;
    req_id_t             pick_winner;

    rr_pick2 u_pick (
        .req_a    (req_a),
        .req_b    (req_b),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= REQ_B;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                last_gnt_q <= pick_winner;
            end
            if (state_q == ACCESS && !we_q) begin
                rdata_q <= ram_data_out;
            end
        end
    end

    // Request fields are only observed through ACCESS-gated outputs, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && pick_valid) begin
            sel_q   <= pick_winner;
            we_q    <= (pick_winner == REQ_B) ? we_b    : we_a;
            addr_q  <= (pick_winner == REQ_B) ? addr_b  : addr_a;
            wdata_q <= (pick_winner == REQ_B) ? wdata_b : wdata_a;
        end
    end

    always_comb begin
        gnt_a       = (state_q == ACCESS) && (sel_q == REQ_A);
        gnt_b       = (state_q == ACCESS) && (sel_q == REQ_B);
        done_a      = (state_q == RESP)   && (sel_q == REQ_A);
        done_b      = (state_q == RESP)   && (sel_q == REQ_B);
        busy        = (state_q != IDLE);
        ram_wr      = (state_q == ACCESS) && we_q;
        ram_rd      = (state_q == ACCESS) && !we_q;
        ram_address = (state_q == ACCESS) ? addr_q : '0;
        ram_data_in = ram_wr ? wdata_q : '0;
        rdata       = rdata_q;
    end

`ifdef RAM_ARB_STATS_EN
    logic [7:0] cnt_a_q, cnt_b_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (gnt_a && cnt_a_q != 8'hFF) cnt_a_q <= cnt_a_q + 8'd1;
            if (gnt_b && cnt_b_q != 8'hFF) cnt_b_q <= cnt_b_q + 8'd1;
        end
    end

    assign gnt_cnt_a = cnt_a_q;
    assign gnt_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 8x8 RAM; covers RAM_ARB_STATS_EN when defined.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_a, req_b, we_a, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, done_a, done_b, busy, ram_wr, ram_rd;
    logic [7:0] rdata, ram_data_in, ram_data_out;
    logic [2:0] ram_address;
`ifdef RAM_ARB_STATS_EN
    logic [7:0] gnt_cnt_a, gnt_cnt_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [8];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_a        (req_a),
        .req_b        (req_b),
        .we_a         (we_a),
        .we_b         (we_b),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .wdata_a      (wdata_a),
        .wdata_b      (wdata_b),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .done_a       (done_a),
        .done_b       (done_b),
        .rdata        (rdata),
        .busy         (busy),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_wr       (ram_wr),
        .ram_rd       (ram_rd),
        .ram_data_out (ram_data_out)
`ifdef RAM_ARB_STATS_EN
        ,
        .gnt_cnt_a    (gnt_cnt_a),
        .gnt_cnt_b    (gnt_cnt_b)
`endif
    );

    assign ram_data_out = mem[ram_address];

    always @(posedge clk) begin
        if (ram_wr) mem[ram_address] <= ram_data_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("strobe_excl", {31'd0, ram_wr & ram_rd}, 32'd0);
        check("gnt_excl",    {31'd0, gnt_a & gnt_b},   32'd0);
        check("done_excl",   {31'd0, done_a & done_b}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        reset_n = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd5; wdata_a = 8'hA5;
        req_b = 1'b0; we_b = 1'b0; addr_b = 3'd0; wdata_b = 8'h00;

        // Reset held two cycles with req_a high
        tick();
        tick();
        check("rst_gnt_a", gnt_a, 1'b0);
        check("rst_busy",  busy,  1'b0);
        check("rst_wr",    ram_wr, 1'b0);
        check("rst_rd",    ram_rd, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_done",  {done_a, done_b}, 2'b00);
`ifdef RAM_ARB_STATS_EN
        check("rst_cnt_a", gnt_cnt_a, 8'd0);
        check("rst_cnt_b", gnt_cnt_b, 8'd0);
`endif

        // A writes 0xA5 to addr 5
        reset_n = 1'b1;
        tick();
        check("wa_gnt_a",  gnt_a, 1'b1);
        check("wa_busy",   busy,  1'b1);
        check("wa_wr",     ram_wr, 1'b1);
        check("wa_rd",     ram_rd, 1'b0);
        check("wa_addr",   ram_address, 3'd5);
        check("wa_din",    ram_data_in, 8'hA5);
        req_a = 1'b0;
        addr_a = 3'd7; wdata_a = 8'hFF;
        tick();
        check("wa_done_a", done_a, 1'b1);
        check("wa_gnt_off", gnt_a, 1'b0);
        check("wa_wr_off", ram_wr, 1'b0);
        check("wa_mem5",   mem[5], 8'hA5);
        check("wa_mem7",   mem[7], 8'h00);
        tick();
        check("wa_idle",   busy, 1'b0);

        // B reads addr 5
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd5;
        tick();
        check("rb_gnt_b",  gnt_b, 1'b1);
        check("rb_rd",     ram_rd, 1'b1);
        check("rb_addr",   ram_address, 3'd5);
        check("rb_din",    ram_data_in, 8'h00);
        req_b = 1'b0;
        tick();
        check("rb_done_b", done_b, 1'b1);
        check("rb_rd_off", ram_rd, 1'b0);
        check("rb_rdata",  rdata, 8'hA5);
        tick();
        check("rb_idle",   busy, 1'b0);

        // Continuous dual demand: A writes 0x3C to addr 3, B reads addr 3
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 8'h3C;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt_a", gnt_a, (k % 2 == 0) ? 1'b1 : 1'b0);
            check("rr_gnt_b", gnt_b, (k % 2 == 1) ? 1'b1 : 1'b0);
            if (k == 3) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            tick();
            check("rr_done_a", done_a, (k % 2 == 0) ? 1'b1 : 1'b0);
            check("rr_done_b", done_b, (k % 2 == 1) ? 1'b1 : 1'b0);
            check("rr_rdata",  rdata, (k == 0) ? 8'hA5 : 8'h3C);
            tick();
            check("rr_idle",   busy, 1'b0);
        end

        // req_b pulsed for one cycle while A's read of addr 5 is in flight
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd5;
        tick();
        check("pb_gnt_a",  gnt_a, 1'b1);
        req_a = 1'b0;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd5; wdata_b = 8'h77;
        tick();
        req_b = 1'b0;
        check("pb_done_a", done_a, 1'b1);
        check("pb_rdata",  rdata, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pb_no_gnt_b",  gnt_b, 1'b0);
            check("pb_no_done_b", done_b, 1'b0);
            check("pb_idle",      busy, 1'b0);
            check("pb_rdata_hold", rdata, 8'hA5);
        end
        check("pb_mem5", mem[5], 8'hA5);

        // Reset asserted in the ACCESS cycle of a B read of addr 2
        mem[2] = 8'h5A;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd2;
        tick();
        check("mr_gnt_b",  gnt_b, 1'b1);
        check("mr_rd",     ram_rd, 1'b1);
        check("mr_addr",   ram_address, 3'd2);
        reset_n = 1'b0;
        req_b = 1'b0;
        tick();
        check("mr_rd_off", ram_rd, 1'b0);
        check("mr_busy",   busy, 1'b0);
        check("mr_done_b", done_b, 1'b0);
        check("mr_rdata",  rdata, 8'h00);
        reset_n = 1'b1;
        tick();
        check("mr_after_done", done_b, 1'b0);
        check("mr_after_busy", busy, 1'b0);

`ifdef RAM_ARB_STATS_EN
        // 300 back-to-back A reads saturate the A counter
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd1;
        for (int k = 0; k < 900; k++) tick();
        req_a = 1'b0;
        tick();
        tick();
        check("st_cnt_a", gnt_cnt_a, 8'd255);
        check("st_cnt_b", gnt_cnt_b, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer for the shared 8x8 scratch RAM (3-bit address, 8-bit data).
- Replaces direct strobe wiring, so two client blocks (A, B) time-share one RAM port.
- Each winning request is latched, one RAM access is driven, then a completion pulse and read data are returned to the winner.

Parameters:
- DATA_W, 8, RAM data width.
- ADDR_W, 3, RAM address width (depth 2**ADDR_W).

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  reset, synchronous, active-low
- req_a / req_b  input  1  access request from A / B; held high until gnt
- we_a / we_b  input  1  1 = write, 0 = read; valid while req high
- addr_a / addr_b  input  ADDR_W  RAM address
- wdata_a / wdata_b  input  DATA_W  write data
- gnt_a / gnt_b  output  1  one-cycle grant pulse; request fields already captured
- done_a / done_b  output  1  one-cycle completion pulse
- rdata  output  DATA_W  read data, valid when done_x for a read
- busy  output  1  high in any state other than IDLE
- ram_address  output  ADDR_W  to RAM address
- ram_data_in  output  DATA_W  to RAM data_in
- ram_wr  output  1  RAM write strobe
- ram_rd  output  1  RAM read strobe
- ram_data_out  input  DATA_W  from RAM data_out, combinational with ram_rd/address

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low, sampled only on the clk rising edge.
- Reset values, applied on the first edge with reset_n = 0:
  - State = IDLE, last_gnt = B (so A wins the first tie).
  - All outputs = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered or decoded from registered state only.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one is high, that requester wins.
  - If both are high, the winner is the requester != last_gnt.
  - On the edge, latch the winner's we/addr/wdata and sel, update last_gnt = winner, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - gnt_<sel> = 1 and busy = 1.
  - ram_address = latched addr; ram_wr = latched we; ram_rd = !latched we.
  - ram_data_in = latched wdata on writes, 0 on reads.
  - On a read, ram_data_out is captured into rdata at the end of the cycle.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - done_<sel> = 1, busy = 1, RAM strobes = 0.
  - rdata holds the captured value until the next read completes; a write does not change rdata.
  - Go to IDLE.
- Latency and throughput:
  - Request in IDLE -> gnt next cycle -> done two cycles after the decision edge.
  - Throughput is one access per 3 cycles under continuous demand.
- Invariants:
  - ram_wr and ram_rd are never high together and never high outside ACCESS.
  - gnt_a & gnt_b == 0 and done_a & done_b == 0 at all times.
- Request dropped before the decision edge: no transaction, no pulses.
- Requester keeps req high through RESP: treated as a new request in IDLE and rotates against the other requester. Under constant dual demand the pattern is A, B, A, B.
- Request fields changing after capture: ignored for the current transaction.
- Reset asserted mid-transaction: next state IDLE, strobes and pulses drop at that edge, no done is issued. A write already strobed in ACCESS may have landed in RAM.
- Address wrap is not applicable; addresses are used as given, no arithmetic.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt_a and gnt_cnt_b (8 bits each).
  - Each counter increments on the corresponding gnt pulse and saturates at 255.
  - Cleared to 0 by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ram_arb_pkg:
  - state_t enum {IDLE, ACCESS, RESP}.
  - req_id_t (1 bit), with localparams REQ_A = 0 and REQ_B = 1.
  - Default DATA_W and ADDR_W localparams.
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req_a, req_b, last_gnt.
  - Outputs: valid, winner.
  - Instantiated once in ram_arbiter.

Test Plan:
- Reset check: reset_n = 0 for 2 cycles with req_a = 1 -> no gnt, busy = 0, all outputs 0; the first grant comes 1 cycle after reset_n rises.
- A write then B read:
  - A writes addr 5, data 0xA5: gnt_a at cycle +1, ram_wr = 1 with ram_address = 5 and ram_data_in = 0xA5, done_a at cycle +2.
  - B then reads addr 5 -> done_b with rdata = 0xA5; ram_rd high for exactly 1 cycle.
- Simultaneous requests after reset, both held for 4 transactions -> grant order A, B, A, B; each done is followed by the next gnt 2 cycles later.
- req_b pulsed for 1 cycle while busy serving A -> no transaction for B, no gnt_b or done_b; rdata keeps A's value.
- Reset mid-transaction: reset_n low in the ACCESS cycle of a B read of addr 2 -> next cycle IDLE, ram_rd = 0, no done_b, rdata = 0.
- RAM_ARB_STATS_EN defined: 300 A-only reads -> gnt_cnt_a = 255 (saturated), gnt_cnt_b = 0.
